div_sched: RTL and testbench
============================

Name: div_sched

Overview:
Sequencer between the EX stage and the shared multi-cycle divider (DIV/DIVU).
- Launches a divide, holds the divider start handshake, and requests a pipeline stall until the result is ready.
- Annuls the divide on flush and aborts it on a watchdog timeout.
- Holds the 64-bit result stable while EX is frozen by a later-stage stall.
- Sits beside ex0/div0; its stall request feeds ctrl.

Parameters:
TIMEOUT, 48, max cycles spent in BUSY before forced abort (the divider normally needs 34)
CNT_W, 6, width of the busy-cycle counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
req_i  in  1  EX holds a DIV/DIVU instruction
signed_i  in  1  1 = DIV, 0 = DIVU
op1_i  in  32  dividend
op2_i  in  32  divisor
ex_stall_i  in  1  EX stage held by the stall vector (stall[3]); instruction not advancing
flush_i  in  1  discard the in-flight EX instruction
div_ready_i  in  1  divider result valid
div_result_i  in  64  {remainder, quotient}
div_start_o  out  1  divider start, held for the whole operation
div_annul_o  out  1  one-cycle divider cancel
div_signed_o  out  1  latched signed flag
div_op1_o  out  32  latched dividend
div_op2_o  out  32  latched divisor
result_o  out  64  held {remainder, quotient} for HI/LO
result_valid_o  out  1  result_o is usable by EX
stallreq_o  out  1  stall request to ctrl
err_o  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0.
  - All registered outputs are 0.
  - div_annul_o stays 0, because the divider is reset too.
- States: IDLE, BUSY, DONE. All outputs except stallreq_o are registered.
- stallreq_o (combinational) = (IDLE & req_i & !flush_i) | BUSY.
- IDLE:
  - If req_i & !flush_i: latch signed_i/op1_i/op2_i into div_*_o, set div_start_o=1, counter=0, go to BUSY.
  - If req_i & flush_i: ignore.
- BUSY:
  - Counter increments every cycle.
  - div_start_o and the operands are held constant.
  - Changes on op*_i are ignored.
- BUSY & div_ready_i & !flush_i:
  - result_o <= div_result_i, result_valid_o <= 1, div_start_o <= 0, go to DONE.
- BUSY & flush_i (takes priority over div_ready_i in the same cycle):
  - div_annul_o=1 for exactly one cycle, div_start_o <= 0, result discarded, go to IDLE.
- BUSY & !req_i & !flush_i: protocol violation; handled exactly like flush (annul, go to IDLE).
- BUSY & counter==TIMEOUT-1 & !div_ready_i:
  - div_annul_o pulse, err_o pulse, result_o <= 0, result_valid_o <= 1, go to DONE.
  - The instruction completes with HI=LO=0.
- DONE:
  - result_valid_o=1, stallreq_o=0.
  - Stays in DONE while ex_stall_i=1, with the result held.
  - When !ex_stall_i (instruction advances) or flush_i: go to IDLE, result_valid_o <= 0, result_o is kept.
- A back-to-back divide is accepted in IDLE the cycle after DONE exits. There is no direct DONE to BUSY path.
- Latency: with req_i at cycle 0 and div_ready_i at cycle N, result_valid_o rises at N+1 and stallreq_o drops in the same cycle.
- The divider handles divide-by-zero itself. This block forwards whatever the divider returns.

Decomposition:
- defines.v: state encodings (DivSchedIdle/Busy/Done), DoubleRegBus, DivStart/DivStop, DivResultReady/NotReady.
- No sub-module: the watchdog counter lives inline; the block is a single FSM.

Test Plan:
- DIV 100/7, req held, model ready after 34 cycles -> div_start_o high 34 cycles; result_o=64'h00000002_0000000E; result_valid_o 1; stallreq_o falls the same cycle.
- DIV -7/2 (op1=32'hFFFFFFF9) -> result_o=64'hFFFFFFFF_FFFFFFFD; DIVU with the same operands -> quotient 32'h7FFFFFFC, remainder 1.
- flush_i at busy cycle 10 -> div_annul_o exactly one cycle, div_start_o 0, result_valid_o never 1, back to IDLE; flush and ready in the same cycle -> same outcome.
- Model never asserts ready -> after 48 busy cycles: err_o one pulse, div_annul_o one pulse, result_o=0, result_valid_o=1.
- ex_stall_i=1 for 5 cycles after ready -> result_o/result_valid_o stable for 5 cycles, then IDLE; an immediate second req relaunches with new operands.
- rst low at busy cycle 12 -> all outputs 0 asynchronously, state IDLE, no annul; after release with req_i=1 a fresh divide starts.

Source files
------------

// File: rtl/div_sched_pkg.sv
// div_sched_pkg: state encodings, widths and bundles shared by the
// EX-side divide sequencer.
package div_sched_pkg;

   localparam int DIV_TIMEOUT = 48;
   localparam int DIV_CNT_W   = 6;
   localparam int DREG_W      = 64;

   localparam logic DIV_START            = 1'b1;
   localparam logic DIV_STOP             = 1'b0;
   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;

   typedef enum logic [1:0] {
      DIV_SCHED_IDLE = 2'd0,
      DIV_SCHED_BUSY = 2'd1,
      DIV_SCHED_DONE = 2'd2
   } div_state_e;

   typedef struct packed {
      logic        sgn;
      logic [31:0] op1;
      logic [31:0] op2;
   } div_op_t;

endpackage

// File: rtl/div_sched.sv
// div_sched: launches a divide on the shared divider, stalls EX until
// the result lands, and holds {rem, quot} while EX is frozen.
module div_sched
   import div_sched_pkg::*;
#(
   parameter int TIMEOUT = DIV_TIMEOUT,
   parameter int CNT_W   = DIV_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_i,
   input  logic              signed_i,
   input  logic [31:0]       op1_i,
   input  logic [31:0]       op2_i,
   input  logic              ex_stall_i,
   input  logic              flush_i,
   input  logic              div_ready_i,
   input  logic [DREG_W-1:0] div_result_i,
   output logic              div_start_o,
   output logic              div_annul_o,
   output logic              div_signed_o,
   output logic [31:0]       div_op1_o,
   output logic [31:0]       div_op2_o,
   output logic [DREG_W-1:0] result_o,
   output logic              result_valid_o,
   output logic              stallreq_o,
   output logic              err_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   div_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   div_op_t           op_q, op_d;
   logic              start_q, start_d;
   logic              annul_q, annul_d;
   logic              err_q, err_d;
   logic              valid_q, valid_d;
   logic [DREG_W-1:0] res_q, res_d;

   logic launch;
   logic kill;
   logic ready;
   logic expired;

   assign launch  = (state_q == DIV_SCHED_IDLE) & req_i & ~flush_i;
   // A vanished request while busy is treated as a flush.
   assign kill    = flush_i | ~req_i;
   assign ready   = (div_ready_i == DIV_RESULT_READY);
   assign expired = (cnt_q == CNT_LAST)
                  & (div_ready_i == DIV_RESULT_NOT_READY);

   assign stallreq_o = launch | (state_q == DIV_SCHED_BUSY);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      start_d = start_q;
      annul_d = 1'b0;
      err_d   = 1'b0;
      valid_d = valid_q;
      res_d   = res_q;
      unique case (state_q)
         DIV_SCHED_IDLE: begin
            if (launch) begin
               op_d.sgn = signed_i;
               op_d.op1 = op1_i;
               op_d.op2 = op2_i;
               start_d  = DIV_START;
               cnt_d    = '0;
               state_d  = DIV_SCHED_BUSY;
            end
         end
         DIV_SCHED_BUSY: begin
            cnt_d = cnt_q + 1'b1;
            if (kill) begin
               annul_d = 1'b1;
               start_d = DIV_STOP;
               state_d = DIV_SCHED_IDLE;
            end else if (ready) begin
               res_d   = div_result_i;
               valid_d = 1'b1;
               start_d = DIV_STOP;
               state_d = DIV_SCHED_DONE;
            end else if (expired) begin
               // Watchdog: retire the instruction with HI=LO=0.
               annul_d = 1'b1;
               err_d   = 1'b1;
               res_d   = '0;
               valid_d = 1'b1;
               start_d = DIV_STOP;
               state_d = DIV_SCHED_DONE;
            end
         end
         DIV_SCHED_DONE: begin
            if (~ex_stall_i | flush_i) begin
               valid_d = 1'b0;
               state_d = DIV_SCHED_IDLE;
            end
         end
         default: begin
            state_d = DIV_SCHED_IDLE;
            start_d = DIV_STOP;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= DIV_SCHED_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         start_q <= DIV_STOP;
         annul_q <= 1'b0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         start_q <= start_d;
         annul_q <= annul_d;
         err_q   <= err_d;
         valid_q <= valid_d;
         res_q   <= res_d;
      end
   end

   assign div_start_o    = start_q;
   assign div_annul_o    = annul_q;
   assign div_signed_o   = op_q.sgn;
   assign div_op1_o      = op_q.op1;
   assign div_op2_o      = op_q.op2;
   assign result_o       = res_q;
   assign result_valid_o = valid_q;
   assign err_o          = err_q;

   a_annul_pulse : assert property (
      @(posedge clk) disable iff (!rst)
      annul_q |=> !annul_q);

   a_busy_hold : assert property (
      @(posedge clk) disable iff (!rst)
      (state_q == DIV_SCHED_BUSY && state_d == DIV_SCHED_BUSY)
      |=> ($stable(op_q) && start_q));

   a_done_nostall : assert property (
      @(posedge clk) disable iff (!rst)
      (state_q == DIV_SCHED_DONE) |-> !stallreq_o);

endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: random and directed divides checked against a
// transaction-level model of launch, stall, kill and watchdog timing.
module tb_div_sched;

   localparam int TMO = 48;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_i = 1'b0;
   logic        signed_i = 1'b0;
   logic [31:0] op1_i = '0;
   logic [31:0] op2_i = '0;
   logic        ex_stall_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        div_ready_i;
   logic [63:0] div_result_i;
   logic        div_start_o;
   logic        div_annul_o;
   logic        div_signed_o;
   logic [31:0] div_op1_o;
   logic [31:0] div_op2_o;
   logic [63:0] result_o;
   logic        result_valid_o;
   logic        stallreq_o;
   logic        err_o;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   lat_cfg = 0;
   int   dcnt    = 0;
   logic force_rdy = 1'b0;
   logic [63:0] last_res;

   function automatic logic [63:0] ref_div(input logic sgn,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      int sa, sb;
      logic [31:0] q, r;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (sgn) begin
         sa = $signed(a);
         sb = $signed(b);
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
      return {r, q};
   endfunction

   always #5 clk = ~clk;

   // Divider model: result after lat_cfg cycles of start.
   always @(posedge clk) dcnt <= div_start_o ? dcnt + 1 : 0;
   assign div_ready_i = (div_start_o && lat_cfg > 0
                         && dcnt == lat_cfg - 1) || force_rdy;
   assign div_result_i = ref_div(div_signed_o, div_op1_o, div_op2_o);

   div_sched dut (
      .clk            (clk),
      .rst            (rst),
      .req_i          (req_i),
      .signed_i       (signed_i),
      .op1_i          (op1_i),
      .op2_i          (op2_i),
      .ex_stall_i     (ex_stall_i),
      .flush_i        (flush_i),
      .div_ready_i    (div_ready_i),
      .div_result_i   (div_result_i),
      .div_start_o    (div_start_o),
      .div_annul_o    (div_annul_o),
      .div_signed_o   (div_signed_o),
      .div_op1_o      (div_op1_o),
      .div_op2_o      (div_op2_o),
      .result_o       (result_o),
      .result_valid_o (result_valid_o),
      .stallreq_o     (stallreq_o),
      .err_o          (err_o)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string pfx);
      chk({pfx, "_ops"}, {div_op1_o, div_op2_o}, 64'd0);
      chk({pfx, "_res"}, result_o, 64'd0);
      chk({pfx, "_ctl"}, 64'({div_start_o, div_annul_o, div_signed_o,
                              result_valid_o, stallreq_o, err_o}), 64'd0);
   endtask

   // kill: 0 none, 1 flush, 2 flush with ready, 3 req dropped
   task automatic run_op(input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input int lat,
                         input int hold, input int kill,
                         input int kill_at);
      logic [63:0] exp_res;
      int n_start, n_annul, n_err, n_stall, vcyc, exp_v;
      bit tmo;
      n_start = 0; n_annul = 0; n_err = 0; n_stall = 0; vcyc = 0;
      tmo     = (lat == 0) || (lat > TMO);
      exp_res = tmo ? 64'd0 : ref_div(sgn, a, b);
      exp_v   = tmo ? TMO + 1 : lat + 1;
      lat_cfg = lat;
      signed_i = sgn; op1_i = a; op2_i = b;
      req_i = 1'b1; flush_i = 1'b0; ex_stall_i = 1'b0;
      #1 chk("stall_launch", 64'(stallreq_o), 64'd1);
      for (int cyc = 1; cyc <= 120; cyc++) begin
         tick();
         n_start += int'(div_start_o);
         n_annul += int'(div_annul_o);
         n_err   += int'(err_o);
         if (cyc == 1) begin
            chk("lat_op1", 64'(div_op1_o), 64'(a));
            chk("lat_op2", 64'(div_op2_o), 64'(b));
            chk("lat_sgn", 64'(div_signed_o), 64'(sgn));
         end
         flush_i = 1'b0;
         force_rdy = 1'b0;
         if (result_valid_o || (kill != 0 && cyc == kill_at + 1)) begin
            vcyc = cyc;
            break;
         end
         n_stall += int'(stallreq_o);
         op1_i = $urandom;
         op2_i = $urandom;
         signed_i = 1'($urandom_range(1));
         if (kill != 0 && cyc == kill_at) begin
            if (kill == 3) req_i = 1'b0;
            else flush_i = 1'b1;
            force_rdy = (kill == 2);
         end
      end
      if (vcyc == 0) begin
         chk("cycle_budget", 64'd0, 64'd1);
         req_i = 1'b0;
         return;
      end
      if (kill != 0) begin
         chk("kill_start_cyc", 64'(n_start), 64'(kill_at));
         chk("kill_annul", 64'(n_annul), 64'd1);
         chk("kill_err", 64'(n_err), 64'd0);
         chk("kill_valid", 64'(result_valid_o), 64'd0);
         chk("kill_start_off", 64'(div_start_o), 64'd0);
         req_i = 1'b0;
         tick();
         chk("kill_annul_off", 64'(div_annul_o), 64'd0);
         chk("kill_idle", 64'(stallreq_o), 64'd0);
         chk("kill_valid2", 64'(result_valid_o), 64'd0);
         return;
      end
      chk("latency", 64'(vcyc), 64'(exp_v));
      chk("result", result_o, exp_res);
      chk("stall_drop", 64'(stallreq_o), 64'd0);
      chk("start_cyc", 64'(n_start), 64'(tmo ? TMO : lat));
      chk("stall_cyc", 64'(n_stall), 64'(exp_v - 1));
      last_res = result_o;
      ex_stall_i = 1'b1;
      for (int h = 0; h < hold; h++) begin
         tick();
         n_annul += int'(div_annul_o);
         n_err   += int'(err_o);
         chk("hold_valid", 64'(result_valid_o), 64'd1);
         chk("hold_result", result_o, exp_res);
         chk("hold_stall", 64'(stallreq_o), 64'd0);
      end
      ex_stall_i = 1'b0;
      req_i = 1'b0;
      tick();
      chk("exit_valid", 64'(result_valid_o), 64'd0);
      chk("exit_result", result_o, exp_res);
      chk("err_pulses", 64'(n_err), 64'(tmo ? 1 : 0));
      chk("annul_pulses", 64'(n_annul), 64'(tmo ? 1 : 0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      logic [31:0] a, b;
      int lat, kill, kat;
      #7;
      chk_zero("reset");
      @(negedge clk) rst = 1'b1;
      tick();

      run_op(1'b1, 32'd100, 32'd7, 34, 0, 0, 0);
      chk("div_100_7", last_res, 64'h00000002_0000000E);
      run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 34, 5, 0, 0);
      chk("div_m7_2", last_res, 64'hFFFFFFFF_FFFFFFFD);
      run_op(1'b0, 32'hFFFF_FFF9, 32'd2, 34, 0, 0, 0);
      chk("divu_m7_2", last_res, 64'h00000001_7FFFFFFC);

      run_op(1'b1, 32'd1234, 32'd5, 34, 0, 1, 10);
      run_op(1'b1, 32'd1234, 32'd5, 34, 0, 2, 10);
      run_op(1'b0, 32'd99, 32'd4, 34, 0, 3, 5);

      run_op(1'b0, 32'd55, 32'd3, 0, 2, 0, 0);
      chk("timeout_res", last_res, 64'd0);
      run_op(1'b0, 32'd55, 32'd3, 48, 0, 0, 0);
      run_op(1'b1, 32'hDEAD_BEEF, 32'd17, 1, 1, 0, 0);

      // Asynchronous reset in the middle of a divide.
      lat_cfg = 34; signed_i = 1'b1;
      op1_i = 32'd1000; op2_i = 32'd9; req_i = 1'b1;
      repeat (12) tick();
      #2 rst = 1'b0;
      req_i = 1'b0;
      #1 chk_zero("rst_async");
      tick();
      chk("rst_no_annul", 64'(div_annul_o), 64'd0);
      @(negedge clk) rst = 1'b1;
      run_op(1'b0, 32'd1000, 32'd9, 20, 0, 0, 0);

      for (int i = 0; i < 25; i++) begin
         a = $urandom;
         b = $urandom;
         if (b == 32'd0) b = 32'd1;
         if (b == 32'hFFFF_FFFF) b = 32'd3;
         lat = $urandom_range(50, 1);
         kill = 0;
         kat = 0;
         if ($urandom_range(4) == 0) begin
            kill = $urandom_range(3, 1);
            kat = $urandom_range((lat < 47) ? lat : 47, 1);
         end
         run_op(1'($urandom_range(1)), a, b, lat,
                $urandom_range(3), kill, kat);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
